// File: rtl/controladora_memoria.sv
// Block transfer engine between main memory and an internal secondary store (STD/LDD); optional bounds check via CTRLMEM_BOUNDS_EN.
// Latency: STD 2*BLK_LEN cycles, LDD BLK_LEN cycles, then DONE until both request lines drop.
// Backpressure: waitTR stalls the control unit for the whole transfer; no new request until requests seen low.
module controladora_memoria #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int SEC_AW  = 6,
    parameter int BLK_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trSTD,
    input  logic              trLDD,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [SEC_AW-1:0] secAddr,
    output logic              waitTR,
    output logic [ADDR_W-1:0] mAddr,
    output logic [DATA_W-1:0] mWdata,
    output logic              mWe,
    input  logic [DATA_W-1:0] mRdata,
    output logic              trErr
);
    typedef enum logic [2:0] {IDLE, STD_RD, STD_WR, LDD_WR, DONE} state_t;

    localparam logic [SEC_AW-1:0] LAST = SEC_AW'(BLK_LEN - 1);

    state_t            state_q;
    logic [SEC_AW-1:0] i_q, i_d, base_s_q, sec_idx_d;
    logic [ADDR_W-1:0] base_m_q, mAddr_q, mAddr_d;
    logic [DATA_W-1:0] mWdata_q;
    logic              mWe_q;
    logic              req, last;
    logic [DATA_W-1:0] sec_q [0:2**SEC_AW-1];

    assign req       = trSTD | trLDD;
    assign last      = (i_q == LAST);
    assign i_d       = i_q + SEC_AW'(1);
    assign sec_idx_d = base_s_q + i_d;
    assign mAddr_d   = base_m_q + ADDR_W'(i_d);

    assign waitTR = !reset && ((state_q == IDLE && req) || state_q == STD_RD ||
                               state_q == STD_WR || state_q == LDD_WR);
    assign mAddr  = mAddr_q;
    assign mWdata = mWdata_q;
    assign mWe    = mWe_q;

`ifdef CTRLMEM_BOUNDS_EN
    localparam logic [SEC_AW+1:0] BLK_W   = (SEC_AW+2)'(BLK_LEN);
    localparam logic [SEC_AW+1:0] DEPTH_W = (SEC_AW+2)'(2**SEC_AW);
    logic err_q, bad;
    assign bad   = ({2'b00, secAddr} + BLK_W) > DEPTH_W;
    assign trErr = err_q;
`else
    assign trErr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            base_m_q <= '0;
            base_s_q <= '0;
            mAddr_q  <= '0;
            mWdata_q <= '0;
            mWe_q    <= 1'b0;
`ifdef CTRLMEM_BOUNDS_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mWe_q <= 1'b0;
                    if (req) begin
                        base_m_q <= memAddr;
                        base_s_q <= secAddr;
                        i_q      <= '0;
`ifdef CTRLMEM_BOUNDS_EN
                        if (bad) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                        end else
`endif
                        if (trSTD) begin
                            state_q <= STD_RD;
                            mAddr_q <= memAddr;
                        end else begin
                            state_q  <= LDD_WR;
                            mAddr_q  <= memAddr;
                            mWdata_q <= sec_q[secAddr];
                            mWe_q    <= 1'b1;
                        end
                    end
                end
                STD_RD: state_q <= STD_WR;
                STD_WR: begin
                    if (last) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= STD_RD;
                        i_q     <= i_d;
                        mAddr_q <= mAddr_d;
                    end
                end
                LDD_WR: begin
                    if (last) begin
                        state_q <= DONE;
                        mWe_q   <= 1'b0;
                    end else begin
                        i_q      <= i_d;
                        mAddr_q  <= mAddr_d;
                        mWdata_q <= sec_q[sec_idx_d];
                    end
                end
                DONE: begin
                    // Hold here until the request level drops so the same request cannot retrigger.
                    if (!req) begin
                        state_q <= IDLE;
`ifdef CTRLMEM_BOUNDS_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store has no reset: words written before a reset survive it.
    always_ff @(posedge clk) begin
        if (state_q == STD_WR)
            sec_q[base_s_q + i_q] <= mRdata;
    end
endmodule
